psk_serializer: RTL and testbench
=================================

Name: psk_serializer

Overview:
Parametrised second-generation PSK/PWM symbol serializer. Pops words from a first-word-fall-through FIFO and shifts BITS_PER_SYMBOL bits of each word onto a single-bit output, holding each bit for a runtime-programmable number of clocks. Adds selectable bit order, optional differential (DBPSK) encoding, a defined idle level, and status outputs (busy, bit_strobe, underrun). Sits between the sample FIFO and the RF output pin, in the same slot as the first-generation modulator.

Parameters:
DATA_WIDTH, 8, FIFO word width.
BITS_PER_SYMBOL, 8, bits serialized per word. Range 2..DATA_WIDTH; elaboration error otherwise.
MAX_CLKS_PER_BIT, 16, upper bound of the runtime clks_per_bit. Sets CPB_WIDTH = $clog2(MAX_CLKS_PER_BIT+1).
MSB_FIRST, 0, 0 = bit 0 first, 1 = bit BITS_PER_SYMBOL-1 first.
DIFF_ENCODE, 0, 1 = output toggles on a '1' data bit (pwm = prev_pwm XOR bit).
IDLE_LEVEL, 0, pwm level in idle/reset; also the differential reference on idle entry.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  clock enable; low freezes all state
clks_per_bit  in  CPB_WIDTH  clocks per bit, latched at each word load; 0 treated as 1, values >MAX saturate to MAX
sample  in  DATA_WIDTH  FIFO head word, valid while empty=0
empty  in  1  FIFO empty
read  out  1  one-cycle FIFO pop pulse
pwm  out  1  registered serial output
busy  out  1  high while in ST_RUN
bit_strobe  out  1  one-cycle pulse in the first cycle each new bit is on pwm
underrun  out  1  one-cycle pulse when a symbol ends with the FIFO empty

Behaviour:
- Reset (async): state=ST_IDLE, counters=0, shift register=0, pwm=IDLE_LEVEL, read=0, bit_strobe=0, underrun=0, busy=0.
- read, bit_strobe and underrun default to 0 every cycle. They are registered pulses, never held for more than one cycle.
- enable=0: state, counters, shift register and pwm hold their values; all pulses are 0.
- ST_IDLE: pwm=IDLE_LEVEL. If empty=0, on the next edge:
  - capture sample and latch clks_per_bit;
  - drive the first bit onto pwm;
  - read=1 and bit_strobe=1 in the following cycle;
  - clk counter=0, bit counter=0, go to ST_RUN.
  - Latency from empty falling to the first bit on pwm: 1 cycle.
- ST_RUN: every bit is held for exactly the latched CPB cycles. On the last clock of a bit that is not the last bit, shift (direction per MSB_FIRST), advance the bit counter, update pwm, and pulse bit_strobe.
- End of symbol (last clock of bit BITS_PER_SYMBOL-1):
  - empty=0: reload exactly as in the ST_IDLE load, with no gap cycle. Symbols are back-to-back.
  - empty=1: go to ST_IDLE, pwm=IDLE_LEVEL, underrun=1 for one cycle.
- Differential: the reference bit is carried across back-to-back symbols and reset to IDLE_LEVEL on idle entry. With DIFF_ENCODE=0, pwm = raw bit.
- empty is sampled only at load points, so the one-cycle-late read pulse never causes a double pop. BITS_PER_SYMBOL>=2 guarantees this.
- clks_per_bit changes mid-symbol have no effect until the next load.
- Any illegal state encoding returns to ST_IDLE.
- Reset mid-symbol aborts immediately. The partially sent word is dropped, and no read or underrun pulse follows.

Decomposition:
- Package psk_pkg:
  - state encoding ST_IDLE/ST_RUN;
  - width helper functions (CPB_WIDTH, bit counter width);
  - parameter range checks.
- Sub-module psk_bit_timer:
  - loadable down-counter with async reset, enable, load value (saturated clks_per_bit);
  - outputs bit_done on the last clock of each bit.
  - The top level holds the FSM, shift register and differential encoder.

Test Plan:
1. LSB-first, DIFF=0, CPB=4, single word 0xA5, then empty -> pwm 1,0,1,0,0,1,0,1, each bit 4 cycles; exactly one read pulse; 8 bit_strobes; underrun pulse at cycle 33; pwm=IDLE_LEVEL afterwards.
2. MSB_FIRST=1, words 0x81,0x3C back-to-back, CPB=2 -> pwm 1000000100111100 with no gap; read pulses 16 cycles apart; no underrun until after the second word.
3. DIFF_ENCODE=1, IDLE_LEVEL=0, word 0x0F LSB-first, CPB=1 -> pwm 1,0,1,0,0,0,0,0. Second word 0x01 back-to-back -> first bit toggles from 0 to 1.
4. clks_per_bit=0 and then 31 (MAX=16) -> bits last 1 and 16 cycles respectively. A change to clks_per_bit mid-symbol does not alter the current symbol.
5. enable low for 5 cycles mid-bit -> pwm and counters frozen; the bit is stretched by exactly 5 cycles; no pulses while enable is low.
6. rst asserted asynchronously mid-symbol (between edges) -> pwm=IDLE_LEVEL and busy=0 immediately; no read/underrun after release; the next non-empty FIFO word loads normally.

Source files
------------

// File: rtl/psk_pkg.sv
// Shared FSM encoding, width helpers and parameter range checks for the PSK/PWM symbol serializer.
package psk_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01
    } psk_state_e;

    function automatic int unsigned cpb_width(input int unsigned max_clks);
        return $clog2(max_clks + 1);
    endfunction

    function automatic int unsigned bit_cnt_width(input int unsigned bits);
        return (bits > 2) ? $clog2(bits) : 1;
    endfunction

    function automatic bit params_ok(input int unsigned bits, input int unsigned width,
                                     input int unsigned max_clks);
        return (bits >= 2) && (bits <= width) && (max_clks >= 1);
    endfunction

endpackage

// File: rtl/psk_bit_timer.sv
// Per-bit down-counter: loaded with the bit length, flags the last clock of each bit.
module psk_bit_timer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             bit_done
);

    logic [WIDTH-1:0] cnt_q;

    // load_val is always >= 1, so the counter holds the clocks remaining after this one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (enable) begin
            if (load) begin
                cnt_q <= load_val - WIDTH'(1);
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - WIDTH'(1);
            end
        end
    end

    assign bit_done = (cnt_q == '0);

endmodule

// File: rtl/psk_serializer.sv
// Serializes FIFO words onto a single pwm pin with programmable bit time, bit order,
// optional differential encoding and busy/strobe/underrun status.
module psk_serializer
    import psk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned BITS_PER_SYMBOL  = 8,
    parameter int unsigned MAX_CLKS_PER_BIT = 16,
    parameter bit          MSB_FIRST        = 1'b0,
    parameter bit          DIFF_ENCODE      = 1'b0,
    parameter bit          IDLE_LEVEL       = 1'b0,
    localparam int unsigned CPB_WIDTH       = cpb_width(MAX_CLKS_PER_BIT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [CPB_WIDTH-1:0]  clks_per_bit,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic                  empty,
    output logic                  read,
    output logic                  pwm,
    output logic                  busy,
    output logic                  bit_strobe,
    output logic                  underrun
);

    localparam int unsigned BCW = bit_cnt_width(BITS_PER_SYMBOL);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(BITS_PER_SYMBOL - 1);

    if (!params_ok(BITS_PER_SYMBOL, DATA_WIDTH, MAX_CLKS_PER_BIT)) begin : g_param_err
        $error("psk_serializer: BITS_PER_SYMBOL must be in 2..DATA_WIDTH");
    end

    psk_state_e                 state_q;
    logic [BITS_PER_SYMBOL-1:0] shift_q;
    logic [BCW-1:0]             bit_cnt_q;
    logic [CPB_WIDTH-1:0]       cpb_q;
    logic [CPB_WIDTH-1:0]       cpb_sat;
    logic                       bit_done;
    logic                       sym_end, adv_bit, load_word;
    logic                       first_bit, next_bit;

    always_comb begin
        cpb_sat = clks_per_bit;
        if (clks_per_bit == '0) begin
            cpb_sat = CPB_WIDTH'(1);
        end else if (32'(clks_per_bit) > MAX_CLKS_PER_BIT) begin
            cpb_sat = CPB_WIDTH'(MAX_CLKS_PER_BIT);
        end
    end

    // empty is only looked at on load points, so the late read pulse cannot double-pop.
    assign sym_end   = (state_q == StRun) && bit_done && (bit_cnt_q == LAST_BIT);
    assign adv_bit   = (state_q == StRun) && bit_done && (bit_cnt_q != LAST_BIT);
    assign load_word = !empty && ((state_q == StIdle) || sym_end);

    assign first_bit = MSB_FIRST ? sample[BITS_PER_SYMBOL-1] : sample[0];
    assign next_bit  = MSB_FIRST ? shift_q[BITS_PER_SYMBOL-2] : shift_q[1];

    psk_bit_timer #(
        .WIDTH (CPB_WIDTH)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .load     (load_word || adv_bit),
        .load_val (load_word ? cpb_sat : cpb_q),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            cpb_q      <= '0;
            pwm        <= IDLE_LEVEL;
            read       <= 1'b0;
            bit_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            read       <= 1'b0;
            bit_strobe <= 1'b0;
            underrun   <= 1'b0;
            if (enable) begin
                if (load_word) begin
                    // pwm already holds the differential reference (idle level or last bit).
                    state_q    <= StRun;
                    shift_q    <= sample[BITS_PER_SYMBOL-1:0];
                    bit_cnt_q  <= '0;
                    cpb_q      <= cpb_sat;
                    pwm        <= DIFF_ENCODE ? (pwm ^ first_bit) : first_bit;
                    read       <= 1'b1;
                    bit_strobe <= 1'b1;
                end else begin
                    unique case (state_q)
                        StIdle: pwm <= IDLE_LEVEL;
                        StRun: begin
                            if (sym_end) begin
                                state_q  <= StIdle;
                                pwm      <= IDLE_LEVEL;
                                underrun <= 1'b1;
                            end else if (adv_bit) begin
                                shift_q    <= MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                                bit_cnt_q  <= bit_cnt_q + BCW'(1);
                                pwm        <= DIFF_ENCODE ? (pwm ^ next_bit) : next_bit;
                                bit_strobe <= 1'b1;
                            end
                        end
                        default: begin
                            state_q <= StIdle;
                            pwm     <= IDLE_LEVEL;
                        end
                    endcase
                end
            end
        end
    end

    assign busy = (state_q == StRun);

endmodule

// File: tb/tb_psk_serializer.sv
// Self-checking bench: four serializer variants in lockstep against a symbol-timing reference model.
module tb_psk_serializer;

    localparam int unsigned BPS  = 8;
    localparam int unsigned MAXC = 16;
    // Variant k: 0 = LSB/plain, 1 = MSB/plain, 2 = LSB/diff, 3 = MSB/diff/idle-high.
    localparam logic [3:0] V_MSB  = 4'b1010;
    localparam logic [3:0] V_DIFF = 4'b1100;
    localparam logic [3:0] V_IDLE = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic [4:0] cpb = 5'd4;
    logic [7:0] sample = 8'h00;
    logic       empty = 1'b1;
    logic [3:0] read, pwm, busy, strobe, under;

    always #5 clk = ~clk;

    psk_serializer #(.MSB_FIRST(1'b0), .DIFF_ENCODE(1'b0), .IDLE_LEVEL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .clks_per_bit(cpb), .sample(sample),
        .empty(empty), .read(read[0]), .pwm(pwm[0]), .busy(busy[0]),
        .bit_strobe(strobe[0]), .underrun(under[0]));
    psk_serializer #(.MSB_FIRST(1'b1), .DIFF_ENCODE(1'b0), .IDLE_LEVEL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .clks_per_bit(cpb), .sample(sample),
        .empty(empty), .read(read[1]), .pwm(pwm[1]), .busy(busy[1]),
        .bit_strobe(strobe[1]), .underrun(under[1]));
    psk_serializer #(.MSB_FIRST(1'b0), .DIFF_ENCODE(1'b1), .IDLE_LEVEL(1'b0)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .clks_per_bit(cpb), .sample(sample),
        .empty(empty), .read(read[2]), .pwm(pwm[2]), .busy(busy[2]),
        .bit_strobe(strobe[2]), .underrun(under[2]));
    psk_serializer #(.MSB_FIRST(1'b1), .DIFF_ENCODE(1'b1), .IDLE_LEVEL(1'b1)) dut3 (
        .clk(clk), .rst(rst), .enable(enable), .clks_per_bit(cpb), .sample(sample),
        .empty(empty), .read(read[3]), .pwm(pwm[3]), .busy(busy[3]),
        .bit_strobe(strobe[3]), .underrun(under[3]));

    // Reference model: position inside a symbol is a plain tick count; bit = tick / cpb.
    bit         m_run, m_ld;
    logic [7:0] m_word;
    int         m_cpb, m_tick;
    logic [3:0] e_pwm;
    bit         e_read, e_strobe, e_under;

    function automatic logic [3:0] emit(input logic [3:0] cur, input logic [7:0] w, input int i);
        logic [3:0] nxt;
        bit b;
        for (int k = 0; k < 4; k++) begin
            b = V_MSB[k] ? w[BPS-1-i] : w[i];
            nxt[k] = V_DIFF[k] ? (cur[k] ^ b) : b;
        end
        return nxt;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_tick = 0; m_cpb = 1; e_pwm = V_IDLE;
            e_read = 0; e_strobe = 0; e_under = 0;
        end else begin
            e_read = 0; e_strobe = 0; e_under = 0; m_ld = 0;
            if (enable) begin
                if (!m_run) begin
                    m_ld = !empty;
                end else begin
                    m_tick++;
                    if (m_tick == BPS * m_cpb) begin
                        if (!empty) m_ld = 1;
                        else begin
                            m_run = 0; e_under = 1; e_pwm = V_IDLE;
                        end
                    end else if (m_tick % m_cpb == 0) begin
                        e_strobe = 1;
                        e_pwm = emit(e_pwm, m_word, m_tick / m_cpb);
                    end
                end
                if (m_ld) begin
                    m_word = sample;
                    m_cpb  = (cpb == 0) ? 1 : ((int'(cpb) > MAXC) ? MAXC : int'(cpb));
                    m_tick = 0; m_run = 1; e_read = 1; e_strobe = 1;
                    e_pwm  = emit(e_pwm, m_word, 0);
                end
            end
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    logic [7:0]  fifo[$];
    bit          rand_mode = 0;
    int          stepno, nbits, nreads, nunder, under_at, read_at0, read_at1, cap_k, rcyc;
    logic [15:0] cap;

    task automatic clr(input int k);
        stepno = 0; nbits = 0; nreads = 0; nunder = 0; under_at = 0;
        read_at0 = 0; read_at1 = 0; cap = '0; cap_k = k;
    endtask

    task automatic drive_fifo();
        empty  = (fifo.size() == 0);
        sample = empty ? 8'($urandom) : fifo[0];
    endtask

    task automatic push(input logic [7:0] w);
        fifo.push_back(w);
        drive_fifo();
    endtask

    task automatic step();
        @(negedge clk);
        stepno++;
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("pwm%0d", k), pwm[k], e_pwm[k]);
            check_eq($sformatf("read%0d", k), read[k], e_read);
            check_eq($sformatf("strobe%0d", k), strobe[k], e_strobe);
            check_eq($sformatf("underrun%0d", k), under[k], e_under);
            check_eq($sformatf("busy%0d", k), busy[k], m_run);
        end
        if (strobe[cap_k]) begin cap = {cap[14:0], pwm[cap_k]}; nbits++; end
        if (read[0]) begin
            nreads++;
            if (nreads == 1) read_at0 = stepno;
            if (nreads == 2) read_at1 = stepno;
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        if (under[cap_k]) begin nunder++; if (under_at == 0) under_at = stepno; end
        if (rand_mode) begin
            rcyc++;
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0)
                cpb = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                  : 5'($urandom_range(0, 3));
            if ((rcyc % 300) < 200 && fifo.size() < 3 && $urandom_range(0, 3) == 0)
                fifo.push_back(8'($urandom));
        end
        drive_fifo();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        clr(0);
        step();
        for (int k = 0; k < 4; k++) begin
            check_eq("rst_pwm", pwm[k], V_IDLE[k]);
            check_eq("rst_busy", busy[k], 0);
        end
        rst = 1'b0;
        run(3);

        // LSB-first 0xA5 at 4 clocks per bit, then underrun.
        clr(0); cpb = 5'd4; push(8'hA5); run(40);
        check_eq("a5_bits", cap[7:0], 8'hA5);
        check_eq("a5_strobes", nbits, 8);
        check_eq("a5_reads", nreads, 1);
        check_eq("a5_under_at", under_at, 33);

        // MSB-first back-to-back 0x81, 0x3C at 2 clocks per bit.
        clr(1); cpb = 5'd2; push(8'h81); push(8'h3C); run(40);
        check_eq("msb_bits", cap, 16'h813C);
        check_eq("msb_read_gap", read_at1 - read_at0, 16);
        check_eq("msb_under_at", under_at, 33);
        check_eq("msb_under_cnt", nunder, 1);

        // Differential: 0x0F then 0x01 back-to-back at 1 clock per bit.
        clr(2); cpb = 5'd1; push(8'h0F); push(8'h01); run(20);
        check_eq("diff_bits", cap, 16'hA0FF);
        check_eq("diff_under_at", under_at, 17);

        // clks_per_bit 0 behaves as 1; 31 saturates to 16 and mid-symbol changes are ignored.
        clr(0); cpb = 5'd0; push(8'h5A); run(12);
        check_eq("cpb0_under_at", under_at, 9);
        clr(0); cpb = 5'd31; push(8'h3C); run(20); cpb = 5'd1; run(120);
        check_eq("cpb31_under_at", under_at, 129);
        check_eq("cpb31_bits", cap[7:0], 8'h3C);

        // Enable low for 5 clocks mid-bit stretches the symbol by 5.
        clr(0); cpb = 5'd4; push(8'h33); run(2);
        enable = 1'b0; run(5); enable = 1'b1; run(40);
        check_eq("en_under_at", under_at, 38);
        check_eq("en_strobes", nbits, 8);

        // Asynchronous reset mid-symbol.
        clr(0); cpb = 5'd4; push(8'hC3); run(6);
        @(posedge clk); #2 rst = 1'b1; #1;
        for (int k = 0; k < 4; k++) begin
            check_eq("arst_pwm", pwm[k], V_IDLE[k]);
            check_eq("arst_busy", busy[k], 0);
        end
        step(); rst = 1'b0;
        clr(0); run(5);
        check_eq("arst_reads", nreads, 0);
        check_eq("arst_under", nunder, 0);
        push(8'h5A); run(40);
        check_eq("arst_reload", cap[7:0], 8'h5A);
        check_eq("arst_reload_reads", nreads, 1);

        // Randomized traffic, enable and bit timing, then drain.
        clr(0); rcyc = 0; rand_mode = 1; run(3000);
        rand_mode = 0; enable = 1'b1; run(500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
